uncenter: RTL and testbench
===========================

UNCENTER -- requirements
Module: uncenter

Interface
REQ-001 SIZE_A, default 8, number of rows (components); each row has one mean entry.
REQ-002 SIZE_B, default 8, number of samples per row.
REQ-003 N_BITS, default 32, output sample width; input sample width is N_BITS+3.
REQ-004 MEAN_BITS, default 24, signed mean entry width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a mean-load then frame-stream sequence.
REQ-008 mean_valid  in  1  mean entry present on mean_in.
REQ-009 mean_in  in  MEAN_BITS signed  mean entry for the current row, delivered in row order 0..SIZE_A-1.
REQ-010 mean_ready  out  1  high only in LOAD state.
REQ-011 in_valid / in_ready  in / out  1 / 1  centered-sample handshake.
REQ-012 in_data  in  N_BITS+3 signed  centered sample, row-major (row 0 col 0 first).
REQ-013 out_valid / out_ready  out / in  1 / 1  restored-sample handshake.
REQ-014 out_data  out  N_BITS signed  in_data plus mean of its row.
REQ-015 out_last  out  1  qualifies the final element (row SIZE_A-1, col SIZE_B-1).
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse after the last element is accepted downstream.

Function
REQ-018 FSM states IDLE, LOAD, STREAM, DRAIN; start in IDLE -> LOAD; start outside IDLE is ignored.
REQ-019 LOAD: each mean_valid&&mean_ready cycle writes mean_in to mean_mem[load_idx] and increments load_idx; after entry SIZE_A-1 -> STREAM.
REQ-020 STREAM: in_ready = !out_valid || out_ready; a transfer occurs when in_valid&&in_ready.
REQ-021 Each accepted sample registers out_data = sext(in_data) + sext(mean_mem[row]) computed at N_BITS+4 bits; latency exactly one cycle from input transfer to out_valid.
REQ-022 col counter wraps at SIZE_B-1 and increments row; the transfer of row SIZE_A-1, col SIZE_B-1 sets out_last with that output and moves to DRAIN.
REQ-023 out_valid/out_data/out_last hold stable while out_valid && !out_ready.
REQ-024 Simultaneous output accept and input accept in the same cycle sustains one sample per cycle with no bubble.
REQ-025 DRAIN: when the last output is accepted, pulse done for one cycle and return to IDLE.
REQ-026 mean_mem is retained across frames in IDLE; no read of unloaded entries occurs.

Reset
REQ-027 rst_n low asynchronously forces IDLE, counters 0, out_valid 0, out_data 0, out_last 0, done 0, busy 0, mean_ready 0, in_ready 0.
REQ-028 Reset mid-LOAD or mid-STREAM discards the partial frame; mean_mem content after reset is undefined and is reloaded by the next start.

Configuration
REQ-029 Macro UNCENTER_SAT_EN defined: sum outside N_BITS signed range saturates to the maximum or minimum N_BITS value.
REQ-030 UNCENTER_SAT_EN undefined: sum is truncated to its low N_BITS bits (two's-complement wrap).

Structure
REQ-031 Package fetal_ecg_pkg holds the FSM state typedef and the default SIZE_A/SIZE_B/N_BITS/MEAN_BITS constants.
REQ-032 One sub-module, uncenter_add, performs the widened add plus the saturate/truncate step; FSM, counters and mean_mem reside in uncenter.

Verification
REQ-033 Load means [100,-50,0,...]; stream 64 samples of 7 with out_ready=1 -> row 0 outputs 107, row 1 outputs -43, row 2 outputs 7; out_last only on element 63; done one cycle after it.
REQ-034 out_ready held low for 5 cycles mid-row -> out_data stable, in_ready low, no sample lost or duplicated.
REQ-035 in_data=2^31-1, mean=1 -> with UNCENTER_SAT_EN out_data=2^31-1; without it, -2^31.
REQ-036 in_data=-2^31, mean=-1 -> with UNCENTER_SAT_EN out_data=-2^31; without it, 2^31-1.
REQ-037 rst_n low during row 3 of STREAM -> all outputs 0 immediately; new start reloads means and completes a full 64-sample frame correctly.
REQ-038 start pulsed during STREAM -> ignored; frame completes with unchanged counts and a single done pulse.

Source files
------------

// File: rtl/fetal_ecg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetal_ecg_pkg
//  Description : Shared FSM state type and default geometry/width constants
//                for the uncenter (mean-restore) block.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetal_ecg_pkg;

  localparam int c_SIZE_A    = 8;   // rows (components), one mean per row
  localparam int c_SIZE_B    = 8;   // samples per row
  localparam int c_N_BITS    = 32;  // output sample width
  localparam int c_MEAN_BITS = 24;  // signed mean entry width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uncenter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uncenter_if
//  Description : Control, mean-load and sample-stream signals of uncenter.
//                'slave' is the design side, 'master' the driving side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uncenter_if
  import fetal_ecg_pkg::*;
#(
  parameter int N_BITS    = c_N_BITS,
  parameter int MEAN_BITS = c_MEAN_BITS
);

  logic                        start;
  logic                        mean_valid;
  logic signed [MEAN_BITS-1:0] mean_in;
  logic                        mean_ready;
  logic                        in_valid;
  logic signed [N_BITS+2:0]    in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [N_BITS-1:0]    out_data;
  logic                        out_last;
  logic                        busy;
  logic                        done;

  modport slave (
    input  start, mean_valid, mean_in, in_valid, in_data, out_ready,
    output mean_ready, in_ready, out_valid, out_data, out_last, busy, done
  );

  modport master (
    output start, mean_valid, mean_in, in_valid, in_data, out_ready,
    input  mean_ready, in_ready, out_valid, out_data, out_last, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/uncenter_add.sv
`default_nettype none
// ============================================================================
//  Module      : uncenter_add
//  Description : Adds a row mean back onto a centered sample at N_BITS+4 bits
//                and narrows the result to N_BITS.
//                UNCENTER_SAT_EN defined   : clamp to the N_BITS signed range.
//                UNCENTER_SAT_EN undefined : keep the low N_BITS (wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module uncenter_add
  import fetal_ecg_pkg::*;
#(
  parameter int N_BITS    = c_N_BITS,
  parameter int MEAN_BITS = c_MEAN_BITS
) (
  input  wire logic signed [N_BITS+2:0]    i_data,
  input  wire logic signed [MEAN_BITS-1:0] i_mean,
  output logic signed [N_BITS-1:0]         o_sum
);

  localparam int W = N_BITS + 4;

  logic signed [W-1:0] w_wide;

  // Both operands are sign-extended before the add, so the sum never overflows.
  assign w_wide = W'(i_data) + W'(i_mean);

`ifdef UNCENTER_SAT_EN
  localparam logic signed [W-1:0] c_MAX = {{(W-N_BITS+1){1'b0}}, {(N_BITS-1){1'b1}}};
  localparam logic signed [W-1:0] c_MIN = {{(W-N_BITS+1){1'b1}}, {(N_BITS-1){1'b0}}};

  // Clamp out-of-range sums to the nearest representable N_BITS value.
  always_comb begin
    o_sum = w_wide[N_BITS-1:0];
    if (w_wide > c_MAX) begin
      o_sum = c_MAX[N_BITS-1:0];
    end else if (w_wide < c_MIN) begin
      o_sum = c_MIN[N_BITS-1:0];
    end
  end
`else
  logic w_unused_hi;

  // Two's-complement wrap: the upper guard bits are simply dropped.
  assign o_sum       = w_wide[N_BITS-1:0];
  assign w_unused_hi = ^w_wide[W-1:N_BITS];
`endif

endmodule
`default_nettype wire

// File: rtl/uncenter.sv
`default_nettype none
// ============================================================================
//  Module      : uncenter
//  Description : Loads one mean per row, then streams a row-major frame of
//                centered samples and adds each row's mean back. One-deep
//                output register with full-throughput ready/valid.
//                Optional saturation via macro UNCENTER_SAT_EN (see
//                uncenter_add); default build wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module uncenter
  import fetal_ecg_pkg::*;
#(
  parameter int SIZE_A    = c_SIZE_A,
  parameter int SIZE_B    = c_SIZE_B,
  parameter int N_BITS    = c_N_BITS,
  parameter int MEAN_BITS = c_MEAN_BITS
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  uncenter_if.slave  bus
);

  localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(SIZE_A - 1);
  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(SIZE_B - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [ROW_W-1:0]            r_load_idx;
  logic [ROW_W-1:0]            r_row;
  logic [COL_W-1:0]            r_col;
  logic signed [MEAN_BITS-1:0] r_mean_mem [SIZE_A];
  logic                        r_out_valid;
  logic                        r_out_last;
  logic signed [N_BITS-1:0]    r_out_data;
  logic                        r_done;

  logic                        w_mean_xfer;
  logic                        w_load_last;
  logic                        w_in_ready;
  logic                        w_in_xfer;
  logic                        w_in_last;
  logic                        w_out_xfer;
  logic                        w_start_ok;
  logic signed [N_BITS-1:0]    w_sum;

  assign w_start_ok  = (r_state == ST_IDLE) && bus.start;
  assign w_mean_xfer = (r_state == ST_LOAD) && bus.mean_valid;
  assign w_load_last = w_mean_xfer && (r_load_idx == c_ROW_LAST);
  // The output register can take a new sample when empty or being drained now.
  assign w_in_ready  = (r_state == ST_STREAM) && (!r_out_valid || bus.out_ready);
  assign w_in_xfer   = w_in_ready && bus.in_valid;
  assign w_in_last   = w_in_xfer && (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
  assign w_out_xfer  = r_out_valid && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start)   w_state_nxt = ST_LOAD;
      ST_LOAD:   if (w_load_last) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_in_last)   w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_out_xfer)  w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Load index and row/column position of the next input sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_idx <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else if (w_start_ok) begin
      r_load_idx <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      if (w_mean_xfer) begin
        r_load_idx <= w_load_last ? '0 : r_load_idx + ROW_W'(1);
      end
      if (w_in_xfer) begin
        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  // Mean storage; contents are rewritten by every LOAD, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_mean_xfer) r_mean_mem[r_load_idx] <= bus.mean_in;
  end

  uncenter_add #(
    .N_BITS    (N_BITS),
    .MEAN_BITS (MEAN_BITS)
  ) u_add (
    .i_data (bus.in_data),
    .i_mean (r_mean_mem[r_row]),
    .o_sum  (w_sum)
  );

  // Output register: load on input transfer, empty on accept, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
      r_out_last  <= w_in_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Completion pulse the cycle after the final element leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (r_state == ST_DRAIN) && w_out_xfer;
  end

  assign bus.mean_ready = (r_state == ST_LOAD);
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_last   = r_out_last;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uncenter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uncenter
//  Description : Self-checking bench for uncenter. Means and samples are
//                generated per frame, expected outputs come from plain
//                integer arithmetic (sum then wrap or clamp to 32 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uncenter;

  typedef struct {
    longint d;
    bit     last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  longint mref [8];
  longint sref [64];

  uncenter_if #(.N_BITS(32), .MEAN_BITS(24)) bus ();

  uncenter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected restored sample: exact integer sum, then narrowed to 32 bits.
  function automatic longint ref_out(input longint x, input longint m);
    longint      s;
    logic [63:0] u;
    s = x + m;
`ifdef UNCENTER_SAT_EN
    if (s > 64'sd2147483647)  return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
`else
    u = s;
    return longint'($signed(u[31:0]));
`endif
  endfunction

  function automatic longint rand_sample();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 2))
      0:       return longint'($signed(t[34:0]));
      1:       return longint'($signed(t[31:0]));
      default: return longint'($signed(t[15:0]));
    endcase
  endfunction

  function automatic longint rand_mean();
    logic [31:0] t;
    t = $urandom();
    return longint'($signed(t[23:0]));
  endfunction

  task automatic randomize_frame();
    for (int i = 0; i < 8; i++)  mref[i] = rand_mean();
    for (int i = 0; i < 64; i++) sref[i] = rand_sample();
  endtask

  task automatic load_means();
    logic [63:0] m;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("load_busy", bus.busy, 1);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.mean_valid = 1'b0;
        @(negedge clk);
      end
      m = mref[i];
      bus.mean_valid = 1'b1;
      bus.mean_in    = m[23:0];
      #1;
      chk("mean_ready", bus.mean_ready, 1);
      @(negedge clk);
    end
    bus.mean_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: 5-cycle output stall, 2: random valid/ready.
  task automatic stream_frame(input int mode, input int rst_at, input int start_at);
    exp_t        q[$];
    exp_t        e;
    int          sent;
    int          cyc;
    int          dones;
    bit          done_due;
    bit          finished;
    bit          ordy;
    bit          ivld;
    bit          out_acc;
    bit          in_acc;
    logic [63:0] dv;
    sent = 0; cyc = 0; dones = 0; done_due = 0; finished = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      chk("done", bus.done, done_due);
      if (bus.done === 1'b1) dones++;
      if (done_due) finished = 1;
      done_due = 0;
      chk("busy", bus.busy, !finished);
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_last", bus.out_last, q[0].last);
      end
      if (finished) break;
      if (rst_at >= 0 && sent == rst_at) begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mean_ready", bus.mean_ready, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = !(cyc >= 12 && cyc < 17);
        default: ordy = ($urandom_range(0, 2) != 0);
      endcase
      ivld = (sent < 64) && (mode != 2 || $urandom_range(0, 3) != 0);
      bus.start     = (cyc == start_at);
      bus.out_ready = ordy;
      bus.in_valid  = ivld;
      dv = (sent < 64) ? sref[sent] : 64'd0;
      bus.in_data   = dv[34:0];
      #1;
      chk("in_ready", bus.in_ready, (sent < 64) && (q.size() == 0 || ordy));
      out_acc = (q.size() != 0) && ordy;
      in_acc  = ivld && (q.size() == 0 || ordy);
      if (out_acc) begin
        if (q[0].last) done_due = 1;
        void'(q.pop_front());
      end
      if (in_acc) begin
        e.d    = ref_out(sref[sent], mref[sent / 8]);
        e.last = (sent == 63);
        q.push_back(e);
        sent++;
      end
      if (cyc > 2000) begin
        total++;
        bad++;
        $error("FAIL timeout: observed=%0d cycles expected=<2000", cyc);
        finished = 1;
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("done_count", dones, 1);
    @(negedge clk);
    chk("done_after", bus.done, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.mean_valid = 1'b0;
    bus.mean_in    = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_last", bus.out_last, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_mean_ready", bus.mean_ready, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frame: means [100,-50,0,...], all samples 7.
    for (int i = 0; i < 8; i++)  mref[i] = 0;
    mref[0] = 100;
    mref[1] = -50;
    for (int i = 0; i < 64; i++) sref[i] = 7;
    chk("ref_row0", ref_out(sref[0], mref[0]), 107);
    chk("ref_row1", ref_out(sref[8], mref[1]), -43);
    chk("ref_row2", ref_out(sref[16], mref[2]), 7);
    load_means();
    stream_frame(0, -1, -1);

    // Mid-row output stall.
    randomize_frame();
    load_means();
    stream_frame(1, -1, -1);

    // Random valid/ready.
    randomize_frame();
    load_means();
    stream_frame(2, -1, -1);

    // Overflow corners: +max + 1 and -min - 1.
    randomize_frame();
    mref[0] = 1;
    mref[1] = -1;
    for (int i = 0; i < 8; i++) begin
      sref[i]     = 64'sd2147483647;
      sref[8 + i] = -64'sd2147483648;
    end
    load_means();
    stream_frame(0, -1, -1);

    // Start pulsed mid-stream is ignored.
    randomize_frame();
    load_means();
    stream_frame(2, -1, 20);

    // Reset during row 3, then a full fresh frame.
    randomize_frame();
    load_means();
    stream_frame(0, 28, -1);
    randomize_frame();
    load_means();
    stream_frame(0, -1, -1);

    chk("final_busy", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
